// File: rtl/cfglut_reconfig_ctrl_if.sv
// rtl/cfglut_reconfig_ctrl_if.sv - request handshake and CFGLUT5 config bus between requester/LUT bank and controller
interface cfglut_reconfig_ctrl_if #(
   parameter int NUM_LUTS = 4,
   parameter int SEL_W    = 2
);
   logic                REQ_VALID;
   logic                REQ_READY;
   logic [SEL_W-1:0]    REQ_SEL;
   logic [31:0]         REQ_INIT;
   logic                CDI;
   logic [NUM_LUTS-1:0] CE;
   logic [NUM_LUTS-1:0] CDO;
   logic                BUSY;
   logic                DONE;
   logic                ERR;
   logic [31:0]         RDBK_DATA;

   // Requester and LUT bank side.
   modport master (
      output REQ_VALID, REQ_SEL, REQ_INIT, CDO,
      input  REQ_READY, CDI, CE, BUSY, DONE, ERR, RDBK_DATA
   );

   // Reconfiguration controller side.
   modport slave (
      input  REQ_VALID, REQ_SEL, REQ_INIT, CDO,
      output REQ_READY, CDI, CE, BUSY, DONE, ERR, RDBK_DATA
   );
endinterface

// File: rtl/cfglut_reconfig_ctrl.sv
// rtl/cfglut_reconfig_ctrl.sv - serial INIT loader for a CFGLUT5 bank; optional readback via CFGLUT_READBACK_EN
module cfglut_reconfig_ctrl #(
   parameter int NUM_LUTS = 4,
   parameter int SEL_W    = 2
) (
   input logic                   CLK,
   input logic                   RST,
   cfglut_reconfig_ctrl_if.slave bus
);

   localparam logic [31:0] NUM_LUTS_W = NUM_LUTS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [4:0]          cnt_q, cnt_d;
   logic [31:0]         shreg_q, shreg_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic                cdi_q, cdi_d;
   logic [NUM_LUTS-1:0] ce_q, ce_d;
   logic                sel_ok;
   logic                accept;

   // Out-of-range selects decode to an all-zero enable, so no LUT is touched.
   function automatic logic [NUM_LUTS-1:0] decode_sel(input logic [SEL_W-1:0] s);
      logic [NUM_LUTS-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_LUTS; i++) begin
         if (32'(s) == 32'(i)) v[i] = 1'b1;
      end
      return v;
   endfunction

   assign sel_ok = (32'(sel_q) < NUM_LUTS_W);
   assign accept = (state_q == IDLE) && bus.REQ_VALID;

   // State, counter, latched request and the registered CE/CDI drive.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         sel_q   <= '0;
         cdi_q   <= 1'b0;
         ce_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         sel_q   <= sel_d;
         cdi_q   <= cdi_d;
         ce_q    <= ce_d;
      end
   end

   // Next state: CDI/CE are computed one cycle ahead so the LUT sees them as flop outputs.
   // shreg holds the bits still to be sent, MSB next, after the one already on CDI.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      sel_d   = sel_q;
      cdi_d   = cdi_q;
      ce_d    = ce_q;
      case (state_q)
         IDLE: begin
            if (bus.REQ_VALID) begin
               sel_d   = bus.REQ_SEL;
               shreg_d = {bus.REQ_INIT[30:0], 1'b0};
               cdi_d   = bus.REQ_INIT[31];
               ce_d    = decode_sel(bus.REQ_SEL);
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               cdi_d   = 1'b0;
               ce_d    = '0;
               state_d = FIN;
            end else begin
               cdi_d   = shreg_q[31];
               shreg_d = {shreg_q[30:0], 1'b0};
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cdi_d   = 1'b0;
            ce_d    = '0;
         end
      endcase
   end

   assign bus.CDI       = cdi_q;
   assign bus.CE        = ce_q;
   assign bus.REQ_READY = (state_q == IDLE);
   assign bus.BUSY      = (state_q != IDLE);
   assign bus.DONE      = (state_q == FIN);
   assign bus.ERR       = (state_q == FIN) && !sel_ok;

`ifdef CFGLUT_READBACK_EN
   logic [31:0] rdbk_q;
   logic        cdo_bit;

   // Old bit 31-k of the selected LUT sits on its CDO just before shift edge k.
   always_comb begin
      cdo_bit = 1'b0;
      for (int i = 0; i < NUM_LUTS; i++) begin
         if (32'(sel_q) == 32'(i)) cdo_bit = bus.CDO[i];
      end
   end

   // Capture the outgoing truth table; cleared on accept, held after FIN.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rdbk_q <= '0;
      end else if (accept) begin
         rdbk_q <= '0;
      end else if (state_q == SHIFT) begin
         rdbk_q <= {rdbk_q[30:0], cdo_bit};
      end
   end

   assign bus.RDBK_DATA = rdbk_q;
`else
   logic unused_cdo;
   logic unused_accept;

   assign unused_cdo    = ^bus.CDO;
   assign unused_accept = accept;
   assign bus.RDBK_DATA = '0;
`endif

endmodule

// File: tb/tb_cfglut_reconfig_ctrl.sv
// tb/tb_cfglut_reconfig_ctrl.sv - randomized self-checking bench with CFGLUT5 bank model
module tb_cfglut_reconfig_ctrl;

   localparam int N  = 3;
   localparam int SW = 2;
   localparam int VW = N + 5;

   logic CLK = 1'b0;
   logic RST;
   logic lut_clr;
   int   total = 0;
   int   bad   = 0;

   logic [31:0] lut     [N];
   logic [31:0] exp_lut [N];

   cfglut_reconfig_ctrl_if #(.NUM_LUTS(N), .SEL_W(SW)) bus ();

   cfglut_reconfig_ctrl #(.NUM_LUTS(N), .SEL_W(SW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   // CFGLUT5 behaviour: shift CDI into bit 0 on each enabled edge, bit 31 on CDO.
   always @(posedge CLK) begin
      for (int i = 0; i < N; i++) begin
         if (lut_clr) lut[i] <= '0;
         else if (bus.CE[i] === 1'b1) lut[i] <= {lut[i][30:0], bus.CDI};
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_cdo
      assign bus.CDO[g] = lut[g][31];
   end

   // Expected {CE,CDI,BUSY,DONE,ERR,READY} in cycle T+c of a request accepted at edge T.
   function automatic logic [VW-1:0] model_out(input int c, input int sel, input logic [31:0] init);
      logic [N-1:0] ce;
      logic [31:0]  iv;
      logic         e;
      iv = init;
      ce = '0;
      if (sel < N) ce[sel] = 1'b1;
      e = (sel >= N);
      if (c >= 1 && c <= 32) return {ce, iv[32-c], 1'b1, 1'b0, 1'b0, 1'b0};
      else if (c == 33)      return {{N{1'b0}}, 1'b0, 1'b1, 1'b1, e, 1'b0};
      else                   return {{N{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   endfunction

   task automatic run_request(input string name, input int sel, input logic [31:0] init, input bit scramble);
      logic [VW-1:0] act, expv;
      logic [31:0]   exp_rd;
      int            w;
      w = 0;
      while (bus.REQ_READY !== 1'b1 && w < 100) begin
         @(posedge CLK); #1;
         w++;
      end
      total++;
      if (bus.REQ_READY !== 1'b1) begin
         bad++;
         $display("FAIL %s ready_wait: REQ_READY=%b required 1", name, bus.REQ_READY);
      end
`ifdef CFGLUT_READBACK_EN
      exp_rd = (sel < N) ? exp_lut[sel] : 32'h0;
`else
      exp_rd = 32'h0;
`endif
      if (sel < N) exp_lut[sel] = init;
      bus.REQ_VALID = 1'b1;
      bus.REQ_SEL   = SW'(sel);
      bus.REQ_INIT  = init;
      @(posedge CLK); #1;
      bus.REQ_VALID = 1'b0;
      for (int c = 1; c <= 34; c++) begin
         if (scramble) begin
            bus.REQ_SEL   = SW'($urandom);
            bus.REQ_INIT  = $urandom;
            bus.REQ_VALID = (c <= 33) ? 1'($urandom) : 1'b0;
         end
         @(negedge CLK);
         act  = {bus.CE, bus.CDI, bus.BUSY, bus.DONE, bus.ERR, bus.REQ_READY};
         expv = model_out(c, sel, init);
         total++;
         if (act !== expv) begin
            bad++;
            $display("FAIL %s T+%0d {CE,CDI,BUSY,DONE,ERR,READY}: got %b required %b", name, c, act, expv);
         end
         if (c >= 33) begin
            total++;
            if (bus.RDBK_DATA !== exp_rd) begin
               bad++;
               $display("FAIL %s T+%0d RDBK_DATA: got %h required %h", name, c, bus.RDBK_DATA, exp_rd);
            end
         end
         @(posedge CLK); #1;
      end
      bus.REQ_VALID = 1'b0;
      for (int i = 0; i < N; i++) begin
         total++;
         if (lut[i] !== exp_lut[i]) begin
            bad++;
            $display("FAIL %s lut%0d contents: got %h required %h", name, i, lut[i], exp_lut[i]);
         end
      end
   endtask

   task automatic test_reset();
      logic [VW-1:0] act;
      RST           = 1'b1;
      lut_clr       = 1'b1;
      bus.REQ_VALID = 1'b0;
      bus.REQ_SEL   = '0;
      bus.REQ_INIT  = '0;
      for (int i = 0; i < N; i++) exp_lut[i] = '0;
      repeat (3) @(posedge CLK);
      #1;
      RST     = 1'b0;
      lut_clr = 1'b0;
      @(negedge CLK);
      act = {bus.CE, bus.CDI, bus.BUSY, bus.DONE, bus.ERR, bus.REQ_READY};
      total++;
      if (act !== model_out(0, 0, 32'h0)) begin
         bad++;
         $display("FAIL reset_outputs: got %b required %b", act, model_out(0, 0, 32'h0));
      end
      total++;
      if (bus.RDBK_DATA !== 32'h0) begin
         bad++;
         $display("FAIL reset_rdbk: got %h required 0", bus.RDBK_DATA);
      end
      @(posedge CLK); #1;
      RST           = 1'b1;
      bus.REQ_VALID = 1'b1;
      bus.REQ_SEL   = 2'd0;
      bus.REQ_INIT  = $urandom;
      @(posedge CLK); #1;
      RST           = 1'b0;
      bus.REQ_VALID = 1'b0;
      @(negedge CLK);
      act = {bus.CE, bus.CDI, bus.BUSY, bus.DONE, bus.ERR, bus.REQ_READY};
      total++;
      if (act !== model_out(0, 0, 32'h0)) begin
         bad++;
         $display("FAIL reset_priority: got %b required %b", act, model_out(0, 0, 32'h0));
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_basic();
      run_request("basic", 2, 32'hA5F0_0F5A, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [VW-1:0] act, expv;
      exp_lut[0] = 32'hFFFF_FFFF;
      exp_lut[1] = 32'h0000_0001;
      bus.REQ_VALID = 1'b1;
      bus.REQ_SEL   = 2'd0;
      bus.REQ_INIT  = 32'hFFFF_FFFF;
      @(posedge CLK); #1;
      bus.REQ_SEL  = 2'd1;
      bus.REQ_INIT = 32'h0000_0001;
      for (int c = 1; c <= 68; c++) begin
         @(negedge CLK);
         act  = {bus.CE, bus.CDI, bus.BUSY, bus.DONE, bus.ERR, bus.REQ_READY};
         expv = (c <= 34) ? model_out(c, 0, 32'hFFFF_FFFF) : model_out(c - 34, 1, 32'h0000_0001);
         total++;
         if (act !== expv) begin
            bad++;
            $display("FAIL b2b T+%0d {CE,CDI,BUSY,DONE,ERR,READY}: got %b required %b", c, act, expv);
         end
         @(posedge CLK); #1;
         if (c == 34) bus.REQ_VALID = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         total++;
         if (lut[i] !== exp_lut[i]) begin
            bad++;
            $display("FAIL b2b lut%0d contents: got %h required %h", i, lut[i], exp_lut[i]);
         end
      end
   endtask

   task automatic test_out_of_range();
      run_request("out_of_range", 3, $urandom, 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [VW-1:0] act;
      logic [31:0]   old, init;
      old  = exp_lut[1];
      init = $urandom;
      bus.REQ_VALID = 1'b1;
      bus.REQ_SEL   = 2'd1;
      bus.REQ_INIT  = init;
      @(posedge CLK); #1;
      bus.REQ_VALID = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (c == 10) RST = 1'b1;
         @(negedge CLK);
         act = {bus.CE, bus.CDI, bus.BUSY, bus.DONE, bus.ERR, bus.REQ_READY};
         total++;
         if (act !== model_out(c, 1, init)) begin
            bad++;
            $display("FAIL reset_mid T+%0d: got %b required %b", c, act, model_out(c, 1, init));
         end
         @(posedge CLK); #1;
      end
      RST = 1'b0;
      @(negedge CLK);
      act = {bus.CE, bus.CDI, bus.BUSY, bus.DONE, bus.ERR, bus.REQ_READY};
      total++;
      if (act !== model_out(0, 0, 32'h0)) begin
         bad++;
         $display("FAIL reset_mid T+11 idle: got %b required %b", act, model_out(0, 0, 32'h0));
      end
      exp_lut[1] = (old << 10) | (init >> 22);
      total++;
      if (lut[1] !== exp_lut[1]) begin
         bad++;
         $display("FAIL reset_mid partial lut1: got %h required %h", lut[1], exp_lut[1]);
      end
      @(posedge CLK); #1;
      run_request("reissue", 1, 32'h1234_5678, 1'b0);
   endtask

   task automatic test_readback();
      run_request("preload", 1, 32'hDEAD_BEEF, 1'b0);
      run_request("readback", 1, 32'h0BAD_F00D, 1'b0);
   endtask

   task automatic test_stability();
      run_request("stability", 2, $urandom, 1'b1);
      run_request("stability_oor", 3, $urandom, 1'b1);
   endtask

   task automatic test_random();
      int gap;
      for (int r = 0; r < 8; r++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) begin
            @(posedge CLK); #1;
         end
         run_request("random", $urandom_range(0, 3), $urandom, 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid();
      test_readback();
      test_stability();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
